// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, FSM states and NZCV bit positions for alu_mc.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_mc_mul.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Iterative shift-add multiplier, one multiplier bit per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mla_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] acc_i,
    output logic              done_o,
    output logic [DATA_W-1:0] prod_o
);

    localparam int                CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q;
    logic [DATA_W-1:0] w_sum_next;

    assign w_sum_next = sum_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            sum_q    <= mla_i ? acc_i : '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            sum_q    <= w_sum_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == C_LAST) begin
                active_q <= 1'b0;
            end
        end
    end

    // The final partial product is forwarded so the caller can latch it on the last step.
    assign done_o = active_q && (cnt_q == C_LAST);
    assign prod_o = w_sum_next;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Registered ARM data-processing ALU with iterative MUL/MLA,
//                internal NZCV register and valid/ready handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_mul,
    input  logic              mla,
    input  logic [3:0]        opcode,
    input  logic              set_flags,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] acc,
    input  logic              shifter_carry,
    input  logic              flag_load,
    input  logic [3:0]        flag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res,
    output logic              res_we,
    output logic [3:0]        nzcv,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              res_we_q, res_we_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              mul_sf_q;

    logic              w_accept;
    logic              w_mul_op;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_prod;

    logic [DATA_W-1:0] w_op1, w_op2, w_logic, w_val;
    logic              w_cin, w_arith, w_cmp;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_dp_res;
    logic              w_dp_we, w_dp_flag_upd;
    logic [3:0]        w_dp_nzcv;

    assign in_ready = ((state_q == IDLE) && (!out_valid_q || out_ready)) ||
                      ((state_q == DONE) && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_mul_op = is_mul && (MUL_EN != 0);

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_iter #(.DATA_W(DATA_W)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start_i (w_accept && w_mul_op),
                .mla_i   (mla),
                .a_i     (a),
                .b_i     (b),
                .acc_i   (acc),
                .done_o  (w_mul_done),
                .prod_o  (w_mul_prod)
            );
        end else begin : g_no_mul
            assign w_mul_done = 1'b0;
            assign w_mul_prod = '0;
        end
    endgenerate

    // Reverse/inverted operand forms are folded into one (DATA_W+1)-bit adder.
    always_comb begin
        w_op1   = a;
        w_op2   = b;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        w_logic = '0;
        case (opcode)
            OP_SUB, OP_CMP: begin w_op2 = ~b; w_cin = 1'b1; end
            OP_RSB:         begin w_op1 = b; w_op2 = ~a; w_cin = 1'b1; end
            OP_ADC:         w_cin = nzcv_q[FLAG_C];
            OP_SBC:         begin w_op2 = ~b; w_cin = nzcv_q[FLAG_C]; end
            OP_RSC:         begin w_op1 = b; w_op2 = ~a; w_cin = nzcv_q[FLAG_C]; end
            OP_AND, OP_TST: begin w_arith = 1'b0; w_logic = a & b; end
            OP_EOR, OP_TEQ: begin w_arith = 1'b0; w_logic = a ^ b; end
            OP_ORR:         begin w_arith = 1'b0; w_logic = a | b; end
            OP_MOV:         begin w_arith = 1'b0; w_logic = b; end
            OP_BIC:         begin w_arith = 1'b0; w_logic = a & ~b; end
            OP_MVN:         begin w_arith = 1'b0; w_logic = ~b; end
            default:        w_cin = 1'b0;
        endcase

        w_sum = {1'b0, w_op1} + {1'b0, w_op2} + {{DATA_W{1'b0}}, w_cin};
        w_val = w_arith ? w_sum[DATA_W-1:0] : w_logic;
        w_cmp = (opcode[3:2] == 2'b10);

        w_dp_nzcv[FLAG_N] = w_val[DATA_W-1];
        w_dp_nzcv[FLAG_Z] = (w_val == '0);
        w_dp_nzcv[FLAG_C] = w_arith ? w_sum[DATA_W] : shifter_carry;
        w_dp_nzcv[FLAG_V] = w_arith ? ((w_op1[DATA_W-1] == w_op2[DATA_W-1]) &&
                                       (w_sum[DATA_W-1] != w_op1[DATA_W-1]))
                                    : nzcv_q[FLAG_V];

        w_dp_res      = w_cmp ? '0 : w_val;
        w_dp_we       = !w_cmp;
        w_dp_flag_upd = set_flags || w_cmp;
        // Multiply request without a multiplier degrades to a flagless MOV of b.
        if (is_mul) begin
            w_dp_res      = b;
            w_dp_we       = 1'b1;
            w_dp_flag_upd = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_we_d    = res_we_q;
        out_valid_d = out_valid_q;
        nzcv_d      = nzcv_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (w_accept && w_mul_op) state_d = MUL;
            end
            MUL: begin
                if (w_mul_done) begin
                    state_d     = DONE;
                    res_d       = w_mul_prod;
                    res_we_d    = 1'b1;
                    out_valid_d = 1'b1;
                    if (mul_sf_q) begin
                        nzcv_d[FLAG_N] = w_mul_prod[DATA_W-1];
                        nzcv_d[FLAG_Z] = (w_mul_prod == '0);
                    end
                end
            end
            DONE: begin
                if (w_accept && w_mul_op) state_d = MUL;
                else if (out_ready)       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (w_accept && !w_mul_op) begin
            res_d       = w_dp_res;
            res_we_d    = w_dp_we;
            out_valid_d = 1'b1;
            if (w_dp_flag_upd) nzcv_d = w_dp_nzcv;
        end

        if (flag_load && (state_q != MUL) &&
            !(w_accept && !w_mul_op && w_dp_flag_upd)) begin
            nzcv_d = flag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            res_q       <= '0;
            res_we_q    <= 1'b0;
            out_valid_q <= 1'b0;
            nzcv_q      <= 4'b0000;
            mul_sf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_we_q    <= res_we_d;
            out_valid_q <= out_valid_d;
            nzcv_q      <= nzcv_d;
            if (w_accept && w_mul_op) mul_sf_q <= set_flags;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign res_we    = res_we_q;
    assign nzcv      = nzcv_q;
    assign busy      = (state_q == MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Directed self-checking bench for alu_mc (DATA_W=32, MUL_EN=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, is_mul, mla, set_flags, shifter_carry;
    logic [3:0]  opcode, flag_in, nzcv;
    logic [31:0] a, b, acc, res;
    logic        flag_load, out_valid, out_ready, res_we, busy;

    int n_chk = 0;
    int n_err = 0;

    alu_mc #(.DATA_W(32), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_mul(is_mul), .mla(mla), .opcode(opcode), .set_flags(set_flags),
        .a(a), .b(b), .acc(acc), .shifter_carry(shifter_carry),
        .flag_load(flag_load), .flag_in(flag_in), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .res_we(res_we), .nzcv(nzcv), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic op(input logic mul, input logic ml, input logic [3:0] opc,
                      input logic sf, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] accv, input logic sc);
        @(negedge clk);
        in_valid = 1'b1; is_mul = mul; mla = ml; opcode = opc; set_flags = sf;
        a = av; b = bv; acc = accv; shifter_carry = sc;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        flag_load = 1'b0;
    endtask

    task automatic fl(input logic [3:0] v);
        @(negedge clk);
        flag_load = 1'b1; flag_in = v;
        @(posedge clk); #1;
        flag_load = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output logic bad);
        cyc = 0; bad = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   cyc;
        logic bad;
        rst = 1'b1; in_valid = 1'b0; is_mul = 1'b0; mla = 1'b0; opcode = 4'h0;
        set_flags = 1'b0; a = '0; b = '0; acc = '0; shifter_carry = 1'b0;
        flag_load = 1'b0; flag_in = 4'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov",   {31'd0, out_valid}, 32'd0);
        chk("rst_res",  res, 32'd0);
        chk("rst_we",   {31'd0, res_we}, 32'd0);
        chk("rst_nzcv", {28'd0, nzcv}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy",  {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Signed overflow into the sign bit
        op(0, 0, OP_ADD, 1, 32'h7FFF_FFFF, 32'h1, 0, 0);
        chk("adds_res",  res, 32'h8000_0000);
        chk("adds_ov",   {31'd0, out_valid}, 32'd1);
        chk("adds_nzcv", {28'd0, nzcv}, 32'h9);

        op(0, 0, OP_SUB, 1, 32'd5, 32'd5, 0, 0);
        chk("subs_res",  res, 32'd0);
        chk("subs_nzcv", {28'd0, nzcv}, 32'h6);

        op(0, 0, OP_CMP, 0, 32'd3, 32'd5, 0, 0);
        chk("cmp_we",   {31'd0, res_we}, 32'd0);
        chk("cmp_res",  res, 32'd0);
        chk("cmp_nzcv", {28'd0, nzcv}, 32'h8);

        // Carry chain: dependent ADC right after ADDS, and again across a flagless ADD
        op(0, 0, OP_ADD, 1, 32'hFFFF_FFFF, 32'h1, 0, 0);
        chk("adds2_nzcv", {28'd0, nzcv}, 32'h6);
        op(0, 0, OP_ADC, 0, 32'd0, 32'd0, 0, 0);
        chk("adc_b2b", res, 32'd1);
        op(0, 0, OP_ADD, 0, 32'd2, 32'd3, 0, 0);
        chk("add_ns_res",  res, 32'd5);
        chk("add_ns_nzcv", {28'd0, nzcv}, 32'h6);
        op(0, 0, OP_ADC, 0, 32'd0, 32'd0, 0, 0);
        chk("adc_after", res, 32'd1);

        // Backpressure with a second op waiting
        op(0, 0, OP_AND, 1, 32'hF0, 32'h3C, 0, 1);
        chk("ands_res",  res, 32'h30);
        chk("ands_nzcv", {28'd0, nzcv}, 32'h2);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; is_mul = 1'b0; opcode = OP_EOR; set_flags = 1'b1;
        a = 32'hFF; b = 32'h0F; shifter_carry = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk("bp_res",  res, 32'h30);
            chk("bp_nzcv", {28'd0, nzcv}, 32'h2);
            chk("bp_ov",   {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("eors_res",  res, 32'hF0);
        chk("eors_nzcv", {28'd0, nzcv}, 32'h0);

        op(0, 0, OP_MVN, 1, 32'd0, 32'd0, 0, 0);
        chk("mvns_res",  res, 32'hFFFF_FFFF);
        chk("mvns_nzcv", {28'd0, nzcv}, 32'h8);
        op(0, 0, OP_TEQ, 0, 32'd5, 32'd5, 0, 1);
        chk("teq_we",   {31'd0, res_we}, 32'd0);
        chk("teq_nzcv", {28'd0, nzcv}, 32'h6);

        op(0, 0, OP_RSB, 1, 32'd1, 32'd0, 0, 0);
        chk("rsbs_res",  res, 32'hFFFF_FFFF);
        chk("rsbs_nzcv", {28'd0, nzcv}, 32'h8);
        op(0, 0, OP_SBC, 1, 32'd5, 32'd3, 0, 0);
        chk("sbcs_res",  res, 32'd1);
        chk("sbcs_nzcv", {28'd0, nzcv}, 32'h2);
        op(0, 0, OP_RSC, 1, 32'd3, 32'd5, 0, 0);
        chk("rscs_res",  res, 32'd2);

        // Direct flag writes and their priority against accepted ops
        fl(4'hF);
        chk("fl_only", {28'd0, nzcv}, 32'hF);
        flag_load = 1'b1; flag_in = 4'hF;
        op(0, 0, OP_ADD, 1, 32'd1, 32'd1, 0, 0);
        chk("fl_vs_adds_res",  res, 32'd2);
        chk("fl_vs_adds_nzcv", {28'd0, nzcv}, 32'h0);
        flag_load = 1'b1; flag_in = 4'h5;
        op(0, 0, OP_ADD, 0, 32'd1, 32'd1, 0, 0);
        chk("fl_with_add", {28'd0, nzcv}, 32'h5);

        // Multiply: latency, zero result, C/V preserved
        fl(4'h3);
        op(1, 0, OP_AND, 1, 32'h0001_0000, 32'h0001_0000, 0, 0);
        chk("muls_busy0", {31'd0, busy}, 32'd1);
        wait_out(cyc, bad);
        chk("muls_lat",  cyc, 32'd32);
        chk("muls_hold", {31'd0, bad}, 32'd0);
        chk("muls_res",  res, 32'd0);
        chk("muls_we",   {31'd0, res_we}, 32'd1);
        chk("muls_nzcv", {28'd0, nzcv}, 32'h7);
        chk("muls_busy", {31'd0, busy}, 32'd0);

        op(1, 1, OP_AND, 0, 32'd3, 32'd4, 32'd5, 0);
        wait_out(cyc, bad);
        chk("mla_lat",  cyc, 32'd32);
        chk("mla_res",  res, 32'd17);
        chk("mla_nzcv", {28'd0, nzcv}, 32'h7);

        // Reset part-way through a multiply
        op(1, 0, OP_AND, 1, 32'd7, 32'd9, 0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_ov",   {31'd0, out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_nzcv", {28'd0, nzcv}, 32'h0);
        chk("mrst_rdy",  {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        op(0, 0, OP_ADD, 1, 32'd2, 32'd2, 0, 0);
        chk("post_rst_add", res, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
